// File: rtl/onchip_ram_arbiter_if.sv
// Avalon-MM style per-master bus between a requester and the on-chip RAM arbiter.
interface onchip_ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_ram_arbiter.sv
// Two-master round-robin arbiter for the single-port on-chip RAM, with read-return tracking.
// Define ONCHIP_RAM_ARB_CONFLICT_CNT_EN to build the saturating dual-request conflict counter.
module onchip_ram_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  onchip_ram_arbiter_if.slave m0,
  onchip_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  output logic                ram_reset_req,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic [15:0]         conflict_count
);

  logic [1:0] req;
  logic [1:0] granted;
  logic       grant_valid;
  logic       win;
  logic       win_write;
  logic       rd_accept;
  logic       last_grant;

  // Read-return pipeline; stage READ_LATENCY lines up with ram_readdata.
  logic [READ_LATENCY:1] vld_pipe;
  logic [READ_LATENCY:1] id_pipe;

  always_comb begin
    req         = {m1.read | m1.write, m0.read | m0.write};
    grant_valid = |req;
    // m1 wins when alone, or on a tie when m0 held the previous grant.
    win         = req[1] & (~req[0] | ~last_grant);
    granted     = 2'b00;
    if (grant_valid) granted = win ? 2'b10 : 2'b01;
    win_write   = win ? m1.write : m0.write;
    rd_accept   = grant_valid & ~reset & ~win_write & (win ? m1.read : m0.read);
  end

  assign m0.waitrequest = reset | (req[0] & ~granted[0]);
  assign m1.waitrequest = reset | (req[1] & ~granted[1]);

  assign ram_address    = win ? m1.address    : m0.address;
  assign ram_byteenable = win ? m1.byteenable : m0.byteenable;
  assign ram_writedata  = win ? m1.writedata  : m0.writedata;
  assign ram_chipselect = grant_valid & ~reset;
  assign ram_write      = win_write & grant_valid & ~reset;
  assign ram_clken      = 1'b1;
  assign ram_reset_req  = reset;

  always_ff @(posedge clk) begin
    if (reset) last_grant <= 1'b1;
    else if (grant_valid) last_grant <= win;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[1] <= rd_accept;
      id_pipe[1]  <= win;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  // Gated by reset so a read caught in flight never strobes during reset.
  assign m0.readdatavalid = vld_pipe[READ_LATENCY] & ~id_pipe[READ_LATENCY] & ~reset;
  assign m1.readdatavalid = vld_pipe[READ_LATENCY] &  id_pipe[READ_LATENCY] & ~reset;
  assign m0.readdata      = ram_readdata;
  assign m1.readdata      = ram_readdata;

`ifdef ONCHIP_RAM_ARB_CONFLICT_CNT_EN
  logic [15:0] cc_q;
  always_ff @(posedge clk) begin
    if (reset) cc_q <= '0;
    else if (&req && cc_q != 16'hFFFF) cc_q <= cc_q + 16'd1;
  end
  assign conflict_count = cc_q;
`else
  assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed bench for onchip_ram_arbiter with a behavioural 1024x32 single-port RAM.
module tb_onchip_ram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken, ram_reset_req;
  logic [31:0] ram_writedata, ram_readdata;
  logic [15:0] conflict_count;
  int          n_tests = 0;
  int          n_fail  = 0;

`ifdef ONCHIP_RAM_ARB_CONFLICT_CNT_EN
  localparam int CC_EXP = 10;
`else
  localparam int CC_EXP = 0;
`endif

  onchip_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m0_bus ();
  onchip_ram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) m1_bus ();

  onchip_ram_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_reset_req(ram_reset_req), .ram_readdata(ram_readdata),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  // Unregistered-output RAM: address captured on the edge, data valid the next cycle.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      ram_readdata <= mem[ram_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_m0(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
    m0_bus.byteenable = be; m0_bus.writedata = d;
  endtask

  task automatic set_m1(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
    m1_bus.byteenable = be; m1_bus.writedata = d;
  endtask

  task automatic idle();
    set_m0(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    set_m1(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_wait0", m0_bus.waitrequest, 1);
    chk("rst_wait1", m1_bus.waitrequest, 1);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_we", ram_write, 0);
    chk("rst_rreq", ram_reset_req, 1);
    chk("rst_rdv0", m0_bus.readdatavalid, 0);
    chk("rst_rdv1", m1_bus.readdatavalid, 0);
    chk("rst_cc", conflict_count, 0);
    chk("clken", ram_clken, 1);
    cyc();

    // m0 write then read back addr 5
    reset = 1'b0;
    set_m0(1'b0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF); #1;
    chk("t1_wr_wait", m0_bus.waitrequest, 0);
    chk("t1_cs", ram_chipselect, 1);
    chk("t1_we", ram_write, 1);
    chk("t1_addr", ram_address, 5);
    chk("t1_rreq", ram_reset_req, 0);
    cyc();
    set_m0(1'b1, 1'b0, 10'd5, 4'hF, 32'h0); #1;
    chk("t1_rd_wait", m0_bus.waitrequest, 0);
    chk("t1_rd_we", ram_write, 0);
    cyc();
    idle();
    chk("t1_rdv0", m0_bus.readdatavalid, 1);
    chk("t1_data", m0_bus.readdata, 32'hDEADBEEF);
    chk("t1_rdv1", m1_bus.readdatavalid, 0);
    cyc();
    chk("t1_rdv0_once", m0_bus.readdatavalid, 0);
    #1;
    chk("t1_idle_cs", ram_chipselect, 0);

    // Preload, reset, then both masters read continuously for 10 cycles
    set_m0(1'b0, 1'b1, 10'd1, 4'hF, 32'h11111111); cyc();
    idle();
    set_m1(1'b0, 1'b1, 10'd2, 4'hF, 32'h22222222); cyc();
    idle();
    reset = 1'b1; cyc();
    reset = 1'b0;
    set_m0(1'b1, 1'b0, 10'd1, 4'hF, 32'h0);
    set_m1(1'b1, 1'b0, 10'd2, 4'hF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t2_wait0_%0d", i), m0_bus.waitrequest, (i % 2));
      chk($sformatf("t2_wait1_%0d", i), m1_bus.waitrequest, 1 - (i % 2));
      chk($sformatf("t2_addr_%0d", i), ram_address, (i % 2) ? 2 : 1);
      cyc();
      chk($sformatf("t2_rdv0_%0d", i), m0_bus.readdatavalid, 1 - (i % 2));
      chk($sformatf("t2_rdv1_%0d", i), m1_bus.readdatavalid, (i % 2));
      chk($sformatf("t2_data_%0d", i), ram_readdata, (i % 2) ? 32'h22222222 : 32'h11111111);
    end
    idle();
    chk("t2_cc", conflict_count, CC_EXP);

    // m1 partial byte write merges into existing word
    set_m1(1'b0, 1'b1, 10'd9, 4'hF, 32'h11223344); cyc();
    set_m1(1'b0, 1'b1, 10'd9, 4'b0010, 32'h0000AB00); cyc();
    set_m1(1'b1, 1'b0, 10'd9, 4'hF, 32'h0); #1;
    chk("t3_wait1", m1_bus.waitrequest, 0);
    cyc();
    idle();
    chk("t3_rdv1", m1_bus.readdatavalid, 1);
    chk("t3_data", m1_bus.readdata, 32'h1122AB44);
    chk("t3_rdv0", m0_bus.readdatavalid, 0);
    cyc();

    // Reset lands one cycle after an m1 read is accepted
    set_m1(1'b1, 1'b0, 10'd2, 4'hF, 32'h0); #1;
    chk("t4_acc", m1_bus.waitrequest, 0);
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("t4_rdv1_%0d", i), m1_bus.readdatavalid, 0);
      chk($sformatf("t4_wait0_%0d", i), m0_bus.waitrequest, 1);
      chk($sformatf("t4_wait1_%0d", i), m1_bus.waitrequest, 1);
      chk($sformatf("t4_rreq_%0d", i), ram_reset_req, 1);
      chk($sformatf("t4_cs_%0d", i), ram_chipselect, 0);
      cyc();
    end
    reset = 1'b0;
    idle(); #1;
    chk("t4_post_rdv1a", m1_bus.readdatavalid, 0);
    chk("t4_post_cc", conflict_count, 0);
    cyc();
    chk("t4_post_rdv1b", m1_bus.readdatavalid, 0);

    // Simultaneous read+write: write wins, no read return
    set_m0(1'b1, 1'b1, 10'd7, 4'hF, 32'h77770007); #1;
    chk("t5_wait0", m0_bus.waitrequest, 0);
    chk("t5_we", ram_write, 1);
    cyc();
    set_m0(1'b1, 1'b0, 10'd7, 4'hF, 32'h0);
    chk("t5_no_rdv", m0_bus.readdatavalid, 0);
    cyc();
    idle();
    chk("t5_rdv0", m0_bus.readdatavalid, 1);
    chk("t5_data", m0_bus.readdata, 32'h77770007);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
